// File: rtl/csi2_lp_crc_check_if.sv
`default_nettype none
// ============================================================================
// Module   : csi2_lp_crc_check_if
// Brief    : Bus bundle for the CSI-2 long-packet CRC checker. Carries the
//            long-packet header, the Gear8 payload beats and the forwarded /
//            result signals. "master" is the upstream side; "slave" is the
//            checker.
// Revision : 1.0 - initial release
// ============================================================================
interface csi2_lp_crc_check_if #(
  parameter int NUM_LANE = 4
);
  // Header and payload from the capture controller
  logic                    lp_en_i;
  logic [5:0]              dt_i;
  logic [1:0]              vc_i;
  logic [15:0]             wc_i;
  logic                    payload_en_i;
  logic [NUM_LANE*8-1:0]   payload_i;

  // Forwarded payload and per-packet result
  logic [NUM_LANE*8-1:0]   data_o;
  logic                    data_en_o;
  logic [NUM_LANE-1:0]     byte_en_o;
  logic                    sop_o;
  logic                    eop_o;
  logic [5:0]              dt_o;
  logic [1:0]              vc_o;
  logic                    crc_valid_o;
  logic                    crc_err_o;
  logic                    pkt_abort_o;
  logic [15:0]             calc_crc_o;
  logic [15:0]             rx_crc_o;
  logic [15:0]             err_cnt_o;

  modport master (
    output lp_en_i, dt_i, vc_i, wc_i, payload_en_i, payload_i,
    input  data_o, data_en_o, byte_en_o, sop_o, eop_o, dt_o, vc_o,
           crc_valid_o, crc_err_o, pkt_abort_o, calc_crc_o, rx_crc_o, err_cnt_o
  );

  modport slave (
    input  lp_en_i, dt_i, vc_i, wc_i, payload_en_i, payload_i,
    output data_o, data_en_o, byte_en_o, sop_o, eop_o, dt_o, vc_o,
           crc_valid_o, crc_err_o, pkt_abort_o, calc_crc_o, rx_crc_o, err_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/csi2_lp_crc_check.sv
`default_nettype none
// ============================================================================
// Module   : csi2_lp_crc_check
// Brief    : Delimits CSI-2 long-packet payloads on the Gear8 path, computes
//            the CRC-16 (0x8408 reflected, seed 0xFFFF) over WC bytes, checks
//            it against the 2-byte footer and forwards the payload with byte
//            enables and SOP/EOP framing.
//            Optional error counter: define CSI2_CRC_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module csi2_lp_crc_check #(
  parameter int NUM_LANE = 4
) (
  input  logic                clk_byte_i,
  input  logic                reset_i,
  csi2_lp_crc_check_if.slave  bus
);

  localparam int LW = NUM_LANE * 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CRC    = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Packet tracking
  state_t          state_q;
  logic [15:0]     rem_q;
  logic [15:0]     crc_q;
  logic [15:0]     rx_q;
  logic [1:0]      ftr_cnt_q;
  logic            first_q;
  logic            eop_done_q;

  // Registered outputs
  logic [5:0]      dt_q;
  logic [1:0]      vc_q;
  logic [LW-1:0]   data_q;
  logic            data_en_q;
  logic [NUM_LANE-1:0] byte_en_q;
  logic            sop_q;
  logic            eop_q;
  logic            crc_valid_q;
  logic            crc_err_q;
  logic            abort_q;
  logic [15:0]     calc_q;
  logic [15:0]     rxo_q;

  // Per-beat combinational results
  logic            hdr_d;
  logic            abort_d;
  logic            last_d;
  logic [2:0]      k_d;
  logic [NUM_LANE-1:0] lane_en_d;
  logic [LW-1:0]   masked_d;
  logic [15:0]     crc_d;
  logic [15:0]     rx_d;
  logic [1:0]      ftr_cnt_d;
  logic            ftr_win_d;
  logic            done_d;
  logic            err_d;

  // One byte through the reflected CCITT CRC, LSB first
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int j = 0; j < 8; j++) begin
      r = (r[0] ^ b[j]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // Split the current beat into data lanes and footer lanes, fold the CRC
  always_comb begin
    hdr_d     = bus.lp_en_i;
    abort_d   = hdr_d && ((state_q == S_DATA) || (state_q == S_CRC));
    last_d    = (rem_q <= 16'(NUM_LANE));
    k_d       = 3'd0;
    if (state_q == S_DATA) begin
      k_d = last_d ? rem_q[2:0] : 3'(NUM_LANE);
    end

    lane_en_d = '0;
    masked_d  = '0;
    crc_d     = crc_q;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (3'(i) < k_d) begin
        lane_en_d[i]      = 1'b1;
        masked_d[i*8 +: 8] = bus.payload_i[i*8 +: 8];
        crc_d             = crc_byte(crc_d, bus.payload_i[i*8 +: 8]);
      end
    end

    // Footer bytes follow the data bytes, possibly spilling into later beats
    ftr_win_d = ((state_q == S_DATA) && last_d) || (state_q == S_CRC);
    ftr_cnt_d = (state_q == S_CRC) ? ftr_cnt_q : 2'd0;
    rx_d      = rx_q;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (ftr_win_d && (3'(i) >= k_d) && (ftr_cnt_d != 2'd2)) begin
        if (ftr_cnt_d == 2'd0) begin
          rx_d[7:0] = bus.payload_i[i*8 +: 8];
        end else begin
          rx_d[15:8] = bus.payload_i[i*8 +: 8];
        end
        ftr_cnt_d = ftr_cnt_d + 2'd1;
      end
    end

    done_d = bus.payload_en_i && !hdr_d && (ftr_cnt_d == 2'd2);
    err_d  = (crc_d != rx_d);
  end

  // Packet FSM with registered forwarding and result outputs
  always_ff @(posedge clk_byte_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      crc_q       <= 16'hFFFF;
      rx_q        <= '0;
      ftr_cnt_q   <= '0;
      first_q     <= 1'b0;
      eop_done_q  <= 1'b0;
      dt_q        <= '0;
      vc_q        <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      byte_en_q   <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      calc_q      <= '0;
      rxo_q       <= '0;
    end else begin
      data_en_q   <= 1'b0;
      byte_en_q   <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      abort_q     <= 1'b0;

      if (hdr_d) begin
        // A header always wins: it starts a new packet and, mid-packet,
        // closes the old one as an aborted error result.
        dt_q       <= bus.dt_i;
        vc_q       <= bus.vc_i;
        rem_q      <= bus.wc_i;
        crc_q      <= 16'hFFFF;
        rx_q       <= '0;
        ftr_cnt_q  <= '0;
        first_q    <= 1'b1;
        eop_done_q <= (bus.wc_i == 16'd0);
        eop_q      <= (bus.wc_i == 16'd0) || (abort_d && !eop_done_q);
        state_q    <= (bus.wc_i != 16'd0) ? S_DATA : S_CRC;
        if (abort_d) begin
          crc_valid_q <= 1'b1;
          crc_err_q   <= 1'b1;
          abort_q     <= 1'b1;
          calc_q      <= crc_q;
          rxo_q       <= rx_q;
        end
      end else begin
        case (state_q)
          S_DATA: begin
            if (bus.payload_en_i) begin
              crc_q     <= crc_d;
              rem_q     <= rem_q - 16'(k_d);
              data_q    <= masked_d;
              data_en_q <= 1'b1;
              byte_en_q <= lane_en_d;
              sop_q     <= first_q;
              first_q   <= 1'b0;
              rx_q      <= rx_d;
              ftr_cnt_q <= ftr_cnt_d;
              if (last_d) begin
                eop_q      <= 1'b1;
                eop_done_q <= 1'b1;
                state_q    <= done_d ? S_RESULT : S_CRC;
              end
            end
          end
          S_CRC: begin
            if (bus.payload_en_i) begin
              rx_q      <= rx_d;
              ftr_cnt_q <= ftr_cnt_d;
              if (done_d) begin
                state_q <= S_RESULT;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase

        if (done_d) begin
          crc_valid_q <= 1'b1;
          crc_err_q   <= err_d;
          calc_q      <= crc_d;
          rxo_q       <= rx_d;
        end
      end
    end
  end

`ifdef CSI2_CRC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Count failed results (mismatch or abort), sticking at all-ones
  always_ff @(posedge clk_byte_i or posedge reset_i) begin
    if (reset_i) begin
      err_cnt_q <= '0;
    end else if ((abort_d || (done_d && err_d)) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_cnt_o = err_cnt_q;
`else
  assign bus.err_cnt_o = 16'h0000;
`endif

  assign bus.dt_o        = dt_q;
  assign bus.vc_o        = vc_q;
  assign bus.data_o      = data_q;
  assign bus.data_en_o   = data_en_q;
  assign bus.byte_en_o   = byte_en_q;
  assign bus.sop_o       = sop_q;
  assign bus.eop_o       = eop_q;
  assign bus.crc_valid_o = crc_valid_q;
  assign bus.crc_err_o   = crc_err_q;
  assign bus.pkt_abort_o = abort_q;
  assign bus.calc_crc_o  = calc_q;
  assign bus.rx_crc_o    = rxo_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_lp_crc_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi2_lp_crc_check
// Brief    : Directed scoreboard bench for csi2_lp_crc_check (NUM_LANE=4).
//            Stimulus pushes expected output cycles into a queue; a monitor
//            on the falling edge pops and compares whenever the DUT emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi2_lp_crc_check;
  localparam int NL = 4;
  localparam int LW = NL * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csi2_lp_crc_check_if #(.NUM_LANE(NL)) bus ();
  csi2_lp_crc_check #(.NUM_LANE(NL)) dut (
    .clk_byte_i (clk),
    .reset_i    (rst),
    .bus        (bus)
  );

  typedef struct {
    int            cyc;
    logic          data_en;
    logic [NL-1:0] be;
    logic          sop;
    logic          eop;
    logic [LW-1:0] data;
    logic [5:0]    dt;
    logic [1:0]    vc;
    logic          crc_valid;
    logic          crc_err;
    logic          abort;
    logic          chk_vals;
    logic [15:0]   calc;
    logic [15:0]   rx;
    logic [15:0]   ecnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          exp_errs = 0;
  string       test_name = "init";
  logic [5:0]  cur_dt;
  logic [1:0]  cur_vc;
  logic [7:0]  pkt[$];
  logic [7:0]  ref_pl [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                               8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                               8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s [%s]: actual=%0h required=%0h", name, test_name, act, req);
    end
  endfunction

  // Reference CRC: xor the byte in, then shift eight times
  function automatic logic [15:0] crc_pkt();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pkt[n]) begin
      c = c ^ {8'h00, pkt[n]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  function automatic exp_t blank(int at);
    exp_t e;
    e.cyc = at; e.data_en = 1'b0; e.be = '0; e.sop = 1'b0; e.eop = 1'b0;
    e.data = '0; e.dt = '0; e.vc = '0; e.crc_valid = 1'b0; e.crc_err = 1'b0;
    e.abort = 1'b0; e.chk_vals = 1'b0; e.calc = '0; e.rx = '0; e.ecnt = '0;
    return e;
  endfunction

  function automatic logic [15:0] ecnt_now();
`ifdef CSI2_CRC_ERR_CNT_EN
    return 16'(exp_errs);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_data"},    32'(bus.data_o), 32'h0);
    chk({tag, "_data_en"}, 32'(bus.data_en_o), 32'h0);
    chk({tag, "_byte_en"}, 32'(bus.byte_en_o), 32'h0);
    chk({tag, "_sop_eop"}, {30'h0, bus.sop_o, bus.eop_o}, 32'h0);
    chk({tag, "_dt_vc"},   {24'h0, bus.dt_o, bus.vc_o}, 32'h0);
    chk({tag, "_result"},  {29'h0, bus.crc_valid_o, bus.crc_err_o, bus.pkt_abort_o}, 32'h0);
    chk({tag, "_crcs"},    {bus.calc_crc_o, bus.rx_crc_o}, 32'h0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt_o), 32'h0);
  endtask

  // Header strobe; an abort result or a zero-length EOP is due next cycle
  task automatic header(input logic [15:0] wc, input logic [5:0] dt, input logic [1:0] vc,
                        input bit abort);
    exp_t e;
    bus.lp_en_i = 1'b1; bus.wc_i = wc; bus.dt_i = dt; bus.vc_i = vc;
    e = blank(cyc + 1);
    if (abort) begin
      exp_errs++;
      e.eop = 1'b1; e.crc_valid = 1'b1; e.crc_err = 1'b1; e.abort = 1'b1;
      e.ecnt = ecnt_now();
    end
    if (wc == 16'd0) e.eop = 1'b1;
    if (abort || (wc == 16'd0)) sb.push_back(e);
    cur_dt = dt; cur_vc = vc;
    tick();
    bus.lp_en_i = 1'b0;
  endtask

  // Payload beats: pkt[] data then the footer, padded with 0xA5
  task automatic body(input int wc, input logic [15:0] ftr, input logic [15:0] exp_calc,
                      input int gap, input int max_beats);
    logic [7:0] s[$];
    int nb;
    exp_t e;
    s = pkt;
    s.push_back(ftr[7:0]);
    s.push_back(ftr[15:8]);
    nb = (wc + 2 + NL - 1) / NL;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      logic [LW-1:0] beat;
      int rem, k;
      if (b > 0) repeat (gap) tick();
      for (int l = 0; l < NL; l++) beat[l*8 +: 8] = (b*NL + l < s.size()) ? s[b*NL + l] : 8'hA5;
      rem = wc - b*NL;
      k = (rem <= 0) ? 0 : ((rem < NL) ? rem : NL);
      e = blank(cyc + 1);
      if (k > 0) begin
        e.data_en = 1'b1; e.sop = (b == 0); e.eop = (rem <= NL);
        e.dt = cur_dt; e.vc = cur_vc;
        for (int l = 0; l < NL; l++) begin
          e.be[l] = (l < k);
          e.data[l*8 +: 8] = (l < k) ? beat[l*8 +: 8] : 8'h00;
        end
      end
      if (b == nb - 1) begin
        e.crc_valid = 1'b1; e.crc_err = (exp_calc != ftr); e.chk_vals = 1'b1;
        e.calc = exp_calc; e.rx = ftr;
        if (e.crc_err) exp_errs++;
        e.ecnt = ecnt_now();
      end
      if (e.data_en || e.crc_valid) sb.push_back(e);
      bus.payload_en_i = 1'b1;
      bus.payload_i = beat;
      tick();
      bus.payload_en_i = 1'b0;
    end
  endtask

  // Monitor: compare every emitting cycle against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_output [%s]: actual=none required=cycle %0d", test_name, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.data_en_o || bus.eop_o || bus.crc_valid_o) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output [%s]: actual=de%0b eop%0b valid%0b required=idle at cycle %0d",
                   test_name, bus.data_en_o, bus.eop_o, bus.crc_valid_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("data_en", 32'(bus.data_en_o), 32'(mon_e.data_en));
          chk("byte_en", 32'(bus.byte_en_o), 32'(mon_e.be));
          chk("sop", 32'(bus.sop_o), 32'(mon_e.sop));
          chk("eop", 32'(bus.eop_o), 32'(mon_e.eop));
          if (mon_e.data_en) begin
            chk("data", 32'(bus.data_o), 32'(mon_e.data));
            chk("dt_vc", {24'h0, bus.dt_o, bus.vc_o}, {24'h0, mon_e.dt, mon_e.vc});
          end
          chk("crc_valid", 32'(bus.crc_valid_o), 32'(mon_e.crc_valid));
          if (mon_e.crc_valid) begin
            chk("crc_err", 32'(bus.crc_err_o), 32'(mon_e.crc_err));
            chk("pkt_abort", 32'(bus.pkt_abort_o), 32'(mon_e.abort));
            chk("err_cnt", 32'(bus.err_cnt_o), 32'(mon_e.ecnt));
            if (mon_e.chk_vals) begin
              chk("calc_crc", 32'(bus.calc_crc_o), 32'(mon_e.calc));
              chk("rx_crc", 32'(bus.rx_crc_o), 32'(mon_e.rx));
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog [%s]: actual=timeout required=finish", test_name);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.lp_en_i = 1'b0; bus.dt_i = '0; bus.vc_i = '0; bus.wc_i = '0;
    bus.payload_en_i = 1'b0; bus.payload_i = '0;
    repeat (3) tick();
    test_name = "reset";
    check_zero("rst");
    rst = 1'b0;
    tick();

    // Reference payload, good footer F0 00
    test_name = "ref_good";
    pkt.delete(); foreach (ref_pl[n]) pkt.push_back(ref_pl[n]);
    header(16'd24, 6'h2A, 2'd1, 1'b0);
    body(24, 16'h00F0, 16'h00F0, 0, 99);

    // Same payload, bad footer F1 00
    test_name = "ref_bad";
    header(16'd24, 6'h2A, 2'd2, 1'b0);
    body(24, 16'h00F1, 16'h00F0, 0, 99);

    // wc=5 with 3-cycle gaps between beats
    test_name = "wc5_gaps";
    pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    header(16'd5, 6'h12, 2'd3, 1'b0);
    repeat (2) tick();
    body(5, crc_pkt(), crc_pkt(), 3, 99);

    // wc=23: footer straddles a beat boundary
    test_name = "wc23_split";
    pkt.delete(); for (int n = 0; n < 23; n++) pkt.push_back(ref_pl[n]);
    header(16'd23, 6'h1E, 2'd0, 1'b0);
    body(23, crc_pkt(), crc_pkt(), 1, 99);

    // Zero-length packets
    test_name = "wc0_good";
    pkt.delete();
    header(16'd0, 6'h30, 2'd1, 1'b0);
    body(0, 16'hFFFF, 16'hFFFF, 0, 99);
    test_name = "wc0_bad";
    header(16'd0, 6'h30, 2'd1, 1'b0);
    body(0, 16'h0000, 16'hFFFF, 0, 99);

    // Abort: a new header after 3 beats of a 64-byte packet
    test_name = "abort";
    pkt.delete(); for (int n = 0; n < 64; n++) pkt.push_back(8'(n * 7 + 3));
    header(16'd64, 6'h2B, 2'd2, 1'b0);
    body(64, 16'h0000, 16'h0000, 0, 3);
    pkt = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    header(16'd8, 6'h2C, 2'd3, 1'b1);
    test_name = "after_abort";
    body(8, crc_pkt(), crc_pkt(), 0, 99);

    // Reset in the middle of a packet
    test_name = "mid_reset";
    pkt.delete(); for (int n = 0; n < 16; n++) pkt.push_back(8'(8'hF0 - n));
    header(16'd16, 6'h24, 2'd1, 1'b0);
    body(16, 16'h0000, 16'h0000, 0, 2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_errs = 0;
    #1;
    check_zero("async_rst");
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Fresh packet after reset
    test_name = "post_reset";
    pkt = {8'h5A, 8'hC3, 8'h0F, 8'h96};
    header(16'd4, 6'h2A, 2'd0, 1'b0);
    body(4, crc_pkt(), crc_pkt(), 0, 99);

    repeat (6) tick();
    test_name = "drain";
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover_expected [%s]: actual=none required=cycle %0d", test_name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
